// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Package : clock_pkg
//  Shared constants for the watch time-set datapath: edit FSM encodings,
//  cursor digit indices and the BCD digit maximum values.
//  Revision: 1.0  initial release
// ============================================================================
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Cursor digit indices; the index also gives the nibble position in the
   // packed BCD time word.
   localparam logic [2:0] CUR_SEC_O = 3'd0;
   localparam logic [2:0] CUR_SEC_T = 3'd1;
   localparam logic [2:0] CUR_MIN_O = 3'd2;
   localparam logic [2:0] CUR_MIN_T = 3'd3;
   localparam logic [2:0] CUR_HR_O  = 3'd4;
   localparam logic [2:0] CUR_HR_T  = 3'd5;

   // Digit maximum values.
   localparam logic [3:0] MAX_ONES     = 4'd9;  // sec/min/hr ones
   localparam logic [3:0] MAX_TENS_MS  = 4'd5;  // sec/min tens
   localparam logic [3:0] MAX_HR_T     = 4'd2;  // hour tens
   localparam logic [3:0] MAX_HR_O_20S = 4'd3;  // hour ones when hour tens is 2

endpackage : clock_pkg
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : time_set_ctrl_if
//  Bundles the time-set controller's control and data signals.
//    mode_set/cursor/up/down : edit controls from the mode FSM / buttons
//    cur_time                : live BCD time from the watch counter
//    load_ack                : watch counter accepted edit_time
//    edit_time/load          : edited time and load request to the counter
//    busy/load_timeout       : status outputs
//  Modports: master drives the controls, slave is the controller.
//  Revision: 1.0  initial release
// ============================================================================
interface time_set_ctrl_if;
   logic        mode_set;
   logic [2:0]  cursor;
   logic        up;
   logic        down;
   logic [23:0] cur_time;
   logic        load_ack;
   logic [23:0] edit_time;
   logic        load;
   logic        busy;
   logic        load_timeout;

   modport master (
      output mode_set, cursor, up, down, cur_time, load_ack,
      input  edit_time, load, busy, load_timeout
   );

   modport slave (
      input  mode_set, cursor, up, down, cur_time, load_ack,
      output edit_time, load, busy, load_timeout
   );
endinterface : time_set_ctrl_if
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
//  Module : bcd_digit_step
//  Combinational single-digit BCD stepper with wrap-around.
//    digit_i : current digit value
//    max_i   : largest legal value for this digit
//    up_i    : increment request
//    down_i  : decrement request
//    next_o  : stepped digit (unchanged if neither or both requests set)
//  Revision: 1.0  initial release
// ============================================================================
module bcd_digit_step (
   input  wire logic [3:0] digit_i,
   input  wire logic [3:0] max_i,
   input  wire logic       up_i,
   input  wire logic       down_i,
   output logic      [3:0] next_o
);

   always_comb begin
      next_o = digit_i;
      if (up_i && !down_i) begin
         // >= rather than == so an out-of-range digit still wraps to 0
         next_o = (digit_i >= max_i) ? 4'd0 : digit_i + 4'd1;
      end else if (down_i && !up_i) begin
         next_o = (digit_i == 4'd0) ? max_i : digit_i - 4'd1;
      end
   end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : time_set_ctrl
//  Captures the live time, lets the user step individual BCD digits, and
//  commits the result to the watch counter with a bounded load handshake.
//    clk  : system clock
//    rst  : asynchronous active-low reset
//    bus  : time_set_ctrl_if.slave (controls in, edit_time/load/status out)
//  Parameter LOAD_TIMEOUT : max COMMIT cycles waiting for load_ack.
//  Revision: 1.0  initial release
// ============================================================================
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int LOAD_TIMEOUT = 255
) (
   input  wire logic       clk,
   input  wire logic       rst,
   time_set_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [23:0]      edit_q, edit_d;
   logic             dirty_q, dirty_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [3:0]  digit_sel;
   logic [3:0]  digit_max;
   logic        cursor_ok;
   logic [3:0]  digit_next;
   logic        step_req;
   logic [23:0] edit_step;

   // ---------------- digit select / step datapath ----------------
   always_comb begin
      digit_sel = 4'd0;
      digit_max = 4'd0;
      cursor_ok = 1'b1;
      case (bus.cursor)
         CUR_SEC_O: begin digit_sel = edit_q[3:0];   digit_max = MAX_ONES;    end
         CUR_SEC_T: begin digit_sel = edit_q[7:4];   digit_max = MAX_TENS_MS; end
         CUR_MIN_O: begin digit_sel = edit_q[11:8];  digit_max = MAX_ONES;    end
         CUR_MIN_T: begin digit_sel = edit_q[15:12]; digit_max = MAX_TENS_MS; end
         CUR_HR_O: begin
            digit_sel = edit_q[19:16];
            digit_max = (edit_q[23:20] == MAX_HR_T) ? MAX_HR_O_20S : MAX_ONES;
         end
         CUR_HR_T:  begin digit_sel = edit_q[23:20]; digit_max = MAX_HR_T;    end
         default:   cursor_ok = 1'b0;
      endcase
   end

   bcd_digit_step u_step (
      .digit_i (digit_sel),
      .max_i   (digit_max),
      .up_i    (bus.up),
      .down_i  (bus.down),
      .next_o  (digit_next)
   );

   assign step_req = (bus.up ^ bus.down) && cursor_ok;

   always_comb begin
      edit_step = edit_q;
      case (bus.cursor)
         CUR_SEC_O: edit_step[3:0]   = digit_next;
         CUR_SEC_T: edit_step[7:4]   = digit_next;
         CUR_MIN_O: edit_step[11:8]  = digit_next;
         CUR_MIN_T: edit_step[15:12] = digit_next;
         CUR_HR_O:  edit_step[19:16] = digit_next;
         CUR_HR_T: begin
            edit_step[23:20] = digit_next;
            // Moving into the 20s must not leave an illegal 24..29 hour.
            if (digit_next == MAX_HR_T && edit_q[19:16] > MAX_HR_O_20S)
               edit_step[19:16] = MAX_HR_O_20S;
         end
         default: edit_step = edit_q;
      endcase
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         edit_q  <= 24'h000000;
         dirty_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         edit_q  <= edit_d;
         dirty_q <= dirty_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      edit_d  = edit_q;
      dirty_d = dirty_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.mode_set) begin
               edit_d  = bus.cur_time;
               dirty_d = 1'b0;
               state_d = ST_EDIT;
            end
         end
         ST_EDIT: begin
            // Steps are only taken while still in set mode so the commit
            // decision below always sees the final dirty flag.
            if (!bus.mode_set) begin
               state_d = dirty_q ? ST_COMMIT : ST_IDLE;
               cnt_d   = '0;
            end else if (step_req) begin
               edit_d  = edit_step;
               dirty_d = 1'b1;
            end
         end
         ST_COMMIT: begin
            if (bus.load_ack || cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      bus.edit_time    = edit_q;
      bus.busy         = (state_q != ST_IDLE);
      bus.load         = (state_q == ST_COMMIT);
      // Pulse during the last COMMIT cycle, while busy is still high.
      bus.load_timeout = (state_q == ST_COMMIT) && !bus.load_ack && (cnt_q == CNT_LAST);
   end

endmodule : time_set_ctrl
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_time_set_ctrl
//  Directed self-checking bench for time_set_ctrl.
//  Revision: 1.0  initial release
// ============================================================================
module tb_time_set_ctrl;

   localparam int TO = 10;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   time_set_ctrl_if bus ();

   time_set_ctrl #(.LOAD_TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [23:0] et, input logic ld,
                           input logic bz, input logic lt);
      chk({tag, ".edit_time"}, {8'h0, bus.edit_time}, {8'h0, et});
      chk({tag, ".load"}, {31'h0, bus.load}, {31'h0, ld});
      chk({tag, ".busy"}, {31'h0, bus.busy}, {31'h0, bz});
      chk({tag, ".load_timeout"}, {31'h0, bus.load_timeout}, {31'h0, lt});
   endtask

   initial begin
      // ---------------- reset holds IDLE even with mode_set high ----------
      rst = 1'b0;
      bus.mode_set = 1'b1;
      bus.cursor   = 3'd0;
      bus.up       = 1'b0;
      bus.down     = 1'b0;
      bus.cur_time = 24'h123456;
      bus.load_ack = 1'b0;
      tick(); tick();
      chk_outs("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
      bus.mode_set = 1'b0;
      rst = 1'b1;
      tick();
      chk_outs("post_reset", 24'h000000, 1'b0, 1'b0, 1'b0);

      // ---------------- 12:34:56, sec-ones x4 up, ack after 3 ----------
      bus.mode_set = 1'b1;
      tick();
      chk_outs("capture", 24'h123456, 1'b0, 1'b1, 1'b0);
      bus.cursor = 3'd0;
      for (int i = 0; i < 4; i++) begin
         bus.up = 1'b1;
         tick();
         bus.up = 1'b0;
         if (i == 0) chk("first_up", {8'h0, bus.edit_time}, 32'h00123457);
         tick();
      end
      chk("sec_wrap", {8'h0, bus.edit_time}, 32'h00123450);
      bus.mode_set = 1'b0;
      tick();
      chk_outs("commit1", 24'h123450, 1'b1, 1'b1, 1'b0);
      bus.up = 1'b1;                     // must be ignored in COMMIT
      tick();
      chk_outs("commit2", 24'h123450, 1'b1, 1'b1, 1'b0);
      bus.up = 1'b0;
      tick();
      chk_outs("commit3", 24'h123450, 1'b1, 1'b1, 1'b0);
      bus.load_ack = 1'b1;
      tick();
      bus.load_ack = 1'b0;
      chk_outs("acked", 24'h123450, 1'b0, 1'b0, 1'b0);
      tick();
      chk_outs("idle_stable", 24'h123450, 1'b0, 1'b0, 1'b0);

      // ---------------- 19:00:00 hour clamp and wraps ----------------
      bus.cur_time = 24'h190000;
      bus.mode_set = 1'b1;
      tick();
      chk("capture2", {8'h0, bus.edit_time}, 32'h00190000);
      bus.cursor = 3'd5; bus.up = 1'b1; tick(); bus.up = 1'b0;
      chk("hr_t_clamp", {8'h0, bus.edit_time}, 32'h00230000);
      bus.cursor = 3'd4; bus.up = 1'b1; tick(); bus.up = 1'b0;
      chk("hr_o_wrap3", {8'h0, bus.edit_time}, 32'h00200000);
      bus.cursor = 3'd3; bus.down = 1'b1; tick(); bus.down = 1'b0;
      chk("min_t_down", {8'h0, bus.edit_time}, 32'h00205000);
      bus.cursor = 3'd4; bus.down = 1'b1; tick(); bus.down = 1'b0;
      chk("hr_o_down", {8'h0, bus.edit_time}, 32'h00235000);
      bus.cursor = 3'd6; bus.up = 1'b1; tick(); bus.up = 1'b0;
      chk("cursor6", {8'h0, bus.edit_time}, 32'h00235000);
      bus.cursor = 3'd1; bus.down = 1'b1; tick(); bus.down = 1'b0;
      chk("sec_t_down", {8'h0, bus.edit_time}, 32'h00235050);

      // ---------------- commit without ack -> timeout ----------------
      bus.mode_set = 1'b0;
      tick();
      chk_outs("to_c1", 24'h235050, 1'b1, 1'b1, 1'b0);
      repeat (TO - 2) tick();
      chk_outs("to_c9", 24'h235050, 1'b1, 1'b1, 1'b0);
      bus.cur_time = 24'h080910;
      bus.mode_set = 1'b1;               // seen by IDLE after the exit
      tick();
      chk_outs("to_pulse", 24'h235050, 1'b1, 1'b1, 1'b1);
      tick();
      chk_outs("to_idle", 24'h235050, 1'b0, 1'b0, 1'b0);
      tick();
      chk_outs("recapture", 24'h080910, 1'b0, 1'b1, 1'b0);

      // ---------------- up+down together: no change, stays clean ------
      bus.cursor = 3'd0; bus.up = 1'b1; bus.down = 1'b1;
      tick();
      bus.up = 1'b0; bus.down = 1'b0;
      chk("up_down", {8'h0, bus.edit_time}, 32'h00080910);
      bus.mode_set = 1'b0;
      tick();
      chk_outs("clean_exit", 24'h080910, 1'b0, 1'b0, 1'b0);
      tick();
      chk_outs("clean_exit2", 24'h080910, 1'b0, 1'b0, 1'b0);

      // ---------------- reset mid-COMMIT ----------------
      bus.cur_time = 24'h000001;
      bus.mode_set = 1'b1;
      tick();
      bus.cursor = 3'd0; bus.up = 1'b1; tick(); bus.up = 1'b0;
      chk("pre_rst_step", {8'h0, bus.edit_time}, 32'h00000002);
      bus.mode_set = 1'b0;
      tick();
      chk("pre_rst_load", {31'h0, bus.load}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk_outs("async_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk_outs("after_rst", 24'h000000, 1'b0, 1'b0, 1'b0);
      tick();
      chk_outs("after_rst2", 24'h000000, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_time_set_ctrl
`default_nettype wire

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 255, maximum cycles COMMIT waits for load_ack before abandoning the commit.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 mode_set  input  1  high while the mode FSM is in time-set mode (its SET_WATCH one-hot bit).
REQ-005 cursor  input  3  selected digit: 0 sec-ones, 1 sec-tens, 2 min-ones, 3 min-tens, 4 hr-ones, 5 hr-tens; 6–7 select nothing.
REQ-006 up  input  1  single-cycle increment request for the selected digit.
REQ-007 down  input  1  single-cycle decrement request for the selected digit.
REQ-008 cur_time  input  24  live BCD time {hr_t, hr_o, min_t, min_o, sec_t, sec_o}, 4 bits per digit.
REQ-009 load_ack  input  1  watch counter accepted edit_time.
REQ-010 edit_time  output  24  BCD time being edited, same packing as cur_time.
REQ-011 load  output  1  request to the watch counter to load edit_time.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 load_timeout  output  1  single-cycle pulse when a commit is abandoned.

Function
REQ-014 The block SHALL implement three states: IDLE, EDIT, COMMIT.
REQ-015 In IDLE with mode_set high, the block SHALL copy cur_time into edit_time, clear dirty, and enter EDIT on the next edge.
REQ-016 In EDIT, up alone SHALL increment the cursor digit, and down alone SHALL decrement it, the change being visible on edit_time one cycle after the request.
REQ-017 up and down high together, or cursor 6–7, SHALL leave edit_time unchanged.
REQ-018 Digit ranges SHALL be: sec/min ones 0–9, sec/min tens 0–5, hr tens 0–2, hr ones 0–9, or 0–3 when hr tens is 2.
REQ-019 Increment at the maximum SHALL wrap to 0, and decrement at 0 SHALL wrap to the maximum.
REQ-020 Any hr-tens change to 2 with hr-ones above 3 SHALL clamp hr-ones to 3 in the same cycle.
REQ-021 Any accepted up/down in EDIT SHALL set dirty.
REQ-022 In EDIT with mode_set low, the block SHALL enter COMMIT if dirty, otherwise IDLE.
REQ-023 In COMMIT, load SHALL be high and edit_time SHALL be held stable, and up/down/cursor/mode_set SHALL be ignored.
REQ-024 In COMMIT, load_ack high SHALL return the block to IDLE with load low on the next cycle.
REQ-025 LOAD_TIMEOUT cycles in COMMIT without load_ack SHALL pulse load_timeout for one cycle and return the block to IDLE.
REQ-026 mode_set high on COMMIT exit SHALL be handled by IDLE on the next cycle, re-capturing cur_time.
REQ-027 edit_time SHALL change only on IDLE capture or an accepted EDIT step.

Reset
REQ-028 While rst is low, the block SHALL hold state IDLE, edit_time 24'h000000, load 0, busy 0, load_timeout 0, dirty 0, and timeout counter 0.
REQ-029 Reset asserted mid-EDIT or mid-COMMIT SHALL discard the edit without issuing load.

Structure
REQ-030 State encodings, cursor digit indices, and digit maximum constants SHALL reside in shared package clock_pkg.
REQ-031 Digit stepping SHALL be a combinational sub-module bcd_digit_step (inputs: digit, max, up, down; output: next digit), instantiated once and muxed by cursor.
REQ-032 The timeout counter SHALL be sized to ceil(log2(LOAD_TIMEOUT+1)) bits.

Verification
REQ-033 cur_time 12:34:56, mode_set rises, cursor 0, 4×up, mode_set falls, load_ack after 3 cycles -> edit_time 12:34:50 and load high exactly 3 cycles then low.
REQ-034 cur_time 19:00:00, cursor 5, up -> edit_time 23:00:00 via clamp; with cursor 4, up -> 20:00:00.
REQ-035 cursor 3 with min-tens 0, down -> min-tens 5; up and down together -> no change and dirty stays 0.
REQ-036 Enter and leave EDIT with no steps -> load never asserts and busy drops one cycle after mode_set falls.
REQ-037 COMMIT with load_ack never asserted -> load_timeout pulses after LOAD_TIMEOUT cycles, then busy drops; rst low mid-COMMIT -> all outputs zero immediately.
